// File: rtl/multiword_add_sequencer_if.sv
// Handshake and operand/result bundle for multiword_add_sequencer.
// The requester uses the master modport; the sequencer uses slave.
interface multiword_add_sequencer_if #(
  parameter int unsigned WORD_WIDTH = 16,
  parameter int unsigned NUM_WORDS  = 4
);
  localparam int unsigned OP_WIDTH = WORD_WIDTH * NUM_WORDS;

  logic                start_valid;
  logic                start_ready;
  logic [OP_WIDTH-1:0] a;
  logic [OP_WIDTH-1:0] b;
  logic                sub;
  logic                c_in;
  logic                result_valid;
  logic                result_ready;
  logic [OP_WIDTH-1:0] sum;
  logic                c_out;
  logic                overflow;
  logic                busy;

  modport master (
    output start_valid, a, b, sub, c_in, result_ready,
    input  start_ready, result_valid, sum, c_out, overflow, busy
  );

  modport slave (
    input  start_valid, a, b, sub, c_in, result_ready,
    output start_ready, result_valid, sum, c_out, overflow, busy
  );
endinterface

// File: rtl/multiword_add_sequencer.sv
// Multi-precision add/subtract: one WORD_WIDTH slice is reused over NUM_WORDS
// cycles, least-significant word first, with the carry chained through a register.
module multiword_add_sequencer #(
  parameter int unsigned WORD_WIDTH = 16,
  parameter int unsigned NUM_WORDS  = 4
) (
  input logic                      clk,
  input logic                      rst,
  multiword_add_sequencer_if.slave bus
);
  localparam int unsigned OP_WIDTH = WORD_WIDTH * NUM_WORDS;
  localparam int unsigned IDX_W    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e              state_q;
  logic [IDX_W-1:0]    idx_q;
  logic                carry_q;
  logic [OP_WIDTH-1:0] a_q;
  logic [OP_WIDTH-1:0] b_q;
  logic [OP_WIDTH-1:0] sum_q;
  logic                c_out_q;
  logic                overflow_q;
  logic                result_valid_q;
  logic                start_ready_q;
  logic                busy_q;

  logic [WORD_WIDTH-1:0] a_word;
  logic [WORD_WIDTH-1:0] b_word;
  logic [WORD_WIDTH:0]   slice;
  logic [OP_WIDTH-1:0]   sum_d;
  logic                  last_word;
  logic                  msb_carry_in;

  always_comb begin
    a_word = '0;
    b_word = '0;
    sum_d  = sum_q;
    for (int unsigned w = 0; w < NUM_WORDS; w++) begin
      if (idx_q == IDX_W'(w)) begin
        a_word = a_q[w*WORD_WIDTH +: WORD_WIDTH];
        b_word = b_q[w*WORD_WIDTH +: WORD_WIDTH];
      end
    end
    slice = {1'b0, a_word} + {1'b0, b_word} + {{WORD_WIDTH{1'b0}}, carry_q};
    for (int unsigned w = 0; w < NUM_WORDS; w++) begin
      if (idx_q == IDX_W'(w)) begin
        sum_d[w*WORD_WIDTH +: WORD_WIDTH] = slice[WORD_WIDTH-1:0];
      end
    end
    last_word    = (idx_q == IDX_W'(NUM_WORDS - 1));
    // Carry into the top bit is recovered from the slice's own MSB inputs/output.
    msb_carry_in = a_word[WORD_WIDTH-1] ^ b_word[WORD_WIDTH-1] ^ slice[WORD_WIDTH-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      idx_q          <= '0;
      carry_q        <= 1'b0;
      a_q            <= '0;
      b_q            <= '0;
      sum_q          <= '0;
      c_out_q        <= 1'b0;
      overflow_q     <= 1'b0;
      result_valid_q <= 1'b0;
      start_ready_q  <= 1'b1;
      busy_q         <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start_valid) begin
            a_q           <= bus.a;
            b_q           <= bus.sub ? ~bus.b : bus.b;
            carry_q       <= bus.sub ^ bus.c_in;
            idx_q         <= '0;
            start_ready_q <= 1'b0;
            busy_q        <= 1'b1;
            state_q       <= RUN;
          end
        end
        RUN: begin
          sum_q   <= sum_d;
          carry_q <= slice[WORD_WIDTH];
          idx_q   <= idx_q + 1'b1;
          if (last_word) begin
            c_out_q        <= slice[WORD_WIDTH];
            overflow_q     <= msb_carry_in ^ slice[WORD_WIDTH];
            result_valid_q <= 1'b1;
            state_q        <= DONE;
          end
        end
        DONE: begin
          if (bus.result_ready) begin
            result_valid_q <= 1'b0;
            start_ready_q  <= 1'b1;
            busy_q         <= 1'b0;
            state_q        <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.start_ready  = start_ready_q;
  assign bus.result_valid = result_valid_q;
  assign bus.sum          = sum_q;
  assign bus.c_out        = c_out_q;
  assign bus.overflow     = overflow_q;
  assign bus.busy         = busy_q;
endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Scoreboard bench for multiword_add_sequencer (W=16, N=4).
module tb_multiword_add_sequencer;
  localparam int unsigned W  = 16;
  localparam int unsigned N  = 4;
  localparam int unsigned OW = W * N;

  typedef struct packed {
    logic [OW-1:0] sum;
    logic          c;
    logic          v;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  multiword_add_sequencer_if #(.WORD_WIDTH(W), .NUM_WORDS(N)) bus ();

  multiword_add_sequencer #(.WORD_WIDTH(W), .NUM_WORDS(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [OW-1:0] got, input logic [OW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [OW-1:0] a, input logic [OW-1:0] b,
                                 input logic sub, input logic cin);
    logic [OW-1:0] beff;
    logic [OW:0]   full;
    exp_t          e;
    beff  = sub ? ~b : b;
    full  = {1'b0, a} + {1'b0, beff} + {{OW{1'b0}}, (sub ^ cin)};
    e.sum = full[OW-1:0];
    e.c   = full[OW];
    e.v   = (a[OW-1] == beff[OW-1]) && (full[OW-1] != a[OW-1]);
    return e;
  endfunction

  task automatic run_op(input logic [OW-1:0] a, input logic [OW-1:0] b,
                        input logic sub, input logic cin, input int hold);
    int   n;
    exp_t e;
    @(negedge clk);
    n = 0;
    while (!bus.start_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("start_ready_idle", bus.start_ready, 1'b1);
    bus.start_valid  = 1'b1;
    bus.a            = a;
    bus.b            = b;
    bus.sub          = sub;
    bus.c_in         = cin;
    bus.result_ready = (hold == 0);
    sb.push_back(model(a, b, sub, cin));
    @(negedge clk);
    bus.start_valid = 1'b0;
    bus.a           = {$urandom, $urandom};
    bus.b           = {$urandom, $urandom};
    bus.sub         = ~sub;
    bus.c_in        = ~cin;
    check("busy_run", bus.busy, 1'b1);
    check("start_ready_run", bus.start_ready, 1'b0);
    n = 0;
    while (!bus.result_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("latency", n, N);
    for (int h = 0; h < hold; h++) begin
      bus.a = {$urandom, $urandom};
      bus.b = {$urandom, $urandom};
      check("hold_valid", bus.result_valid, 1'b1);
      check("hold_sum", bus.sum, (sb.size() > 0) ? sb[0].sum : '0);
      check("hold_start_ready", bus.start_ready, 1'b0);
      @(negedge clk);
    end
    bus.result_ready = 1'b1;
    e = (sb.size() > 0) ? sb.pop_front() : '0;
    check("result_valid", bus.result_valid, 1'b1);
    check("sum", bus.sum, e.sum);
    check("c_out", bus.c_out, e.c);
    check("overflow", bus.overflow, e.v);
    @(negedge clk);
    check("valid_cleared", bus.result_valid, 1'b0);
    check("start_ready_back", bus.start_ready, 1'b1);
    check("busy_cleared", bus.busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start_valid  = 1'b0;
    bus.a            = '0;
    bus.b            = '0;
    bus.sub          = 1'b0;
    bus.c_in         = 1'b0;
    bus.result_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_start_ready", bus.start_ready, 1'b1);
    check("rst_valid", bus.result_valid, 1'b0);
    check("rst_sum", bus.sum, '0);
    check("rst_c_out", bus.c_out, 1'b0);
    check("rst_overflow", bus.overflow, 1'b0);
    check("rst_busy", bus.busy, 1'b0);

    run_op(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0, 0);
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b0, 1'b1, 0);
    run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 0);
    run_op(64'h5, 64'h7, 1'b1, 1'b0, 0);
    run_op(64'h7, 64'h5, 1'b1, 1'b0, 0);
    run_op(64'h8000_0000_0000_0000, 64'h1, 1'b1, 1'b1, 0);
    run_op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b1, 10);

    for (int i = 0; i < 8; i++) begin
      run_op({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'($urandom),
             int'($urandom_range(0, 2)));
    end

    // Abort: reset sampled on the second RUN edge.
    @(negedge clk);
    bus.start_valid = 1'b1;
    bus.a           = 64'h1;
    bus.b           = 64'h2;
    bus.sub         = 1'b0;
    bus.c_in        = 1'b0;
    @(negedge clk);
    bus.start_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_start_ready", bus.start_ready, 1'b1);
    check("abort_valid", bus.result_valid, 1'b0);
    check("abort_sum", bus.sum, '0);
    check("abort_busy", bus.busy, 1'b0);
    run_op(64'h3, 64'h4, 1'b0, 1'b0, 0);

    check("sb_empty", 64'(sb.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
